// File: rtl/program_mem_arbiter_pkg.sv
// Shared constants and master identifiers for the program-memory arbiter slice.
// The memory geometry is 1024 x 32 with byte lanes.
package program_mem_pkg;

    localparam int PM_ADDR_W = 10;
    localparam int PM_DATA_W = 32;
    localparam int PM_BE_W   = PM_DATA_W / 8;

    typedef enum logic {
        PM_M_IFETCH = 1'b0,
        PM_M_DATA   = 1'b1
    } pm_master_e;

endpackage

// File: rtl/program_mem_arbiter_if.sv
// Avalon-MM master-side bundle for one arbiter port.
// The instruction-fetch port uses the read-only ifetch_slave view.
interface program_mem_arbiter_if
    import program_mem_pkg::*;
#(
    parameter int ADDR_W = PM_ADDR_W,
    parameter int DATA_W = PM_DATA_W,
    parameter int BE_W   = PM_BE_W
);

    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              debugaccess;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata, debugaccess,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata, debugaccess,
        output waitrequest, readdata, readdatavalid
    );

    modport ifetch_slave (
        input  address, read,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/program_mem_arbiter_rr_arb2.sv
// Two-requester grant logic with a last-grant register.
// FIXED_PRI=1 makes requester 1 win every tie.
module rr_arb2
    import program_mem_pkg::*;
#(
    parameter int FIXED_PRI = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_grant0,
    output logic o_grant1
);

    pm_master_e r_last_grant;

    always_comb begin
        o_grant0 = 1'b0;
        o_grant1 = 1'b0;
        if (i_req0 && i_req1) begin
            if ((FIXED_PRI != 0) || (r_last_grant == PM_M_IFETCH)) begin
                o_grant1 = 1'b1;
            end else begin
                o_grant0 = 1'b1;
            end
        end else begin
            o_grant0 = i_req0;
            o_grant1 = i_req1;
        end
    end

    // Reset to the data master so the fetch port wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= PM_M_DATA;
        end else if (o_grant0 || o_grant1) begin
            r_last_grant <= o_grant1 ? PM_M_DATA : PM_M_IFETCH;
        end
    end

endmodule

// File: rtl/program_mem_arbiter.sv
// Arbiter between instruction fetch (m0, read-only) and data/debug (m1) ports
// in front of the single-port program memory with 1-cycle read latency.
module program_mem_arbiter
    import program_mem_pkg::*;
#(
    parameter int ADDR_W    = PM_ADDR_W,
    parameter int DATA_W    = PM_DATA_W,
    parameter int BE_W      = PM_BE_W,
    parameter int FIXED_PRI = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    program_mem_arbiter_if.ifetch_slave m0,
    program_mem_arbiter_if.slave      m1,
    output logic [ADDR_W-1:0]         mem_address,
    output logic [BE_W-1:0]           mem_byteenable,
    output logic                      mem_chipselect,
    output logic                      mem_clken,
    output logic                      mem_write,
    output logic [DATA_W-1:0]         mem_writedata,
    output logic                      mem_debugaccess,
    input  logic [DATA_W-1:0]         mem_readdata
);

    logic       w_req0;
    logic       w_req1;
    logic       w_grant0;
    logic       w_grant1;
    logic       w_rd_accept;
    logic       r_rd_pend;
    pm_master_e r_rd_owner;

    // Requests are masked while in reset so nothing is granted or recorded.
    assign w_req0 = reset_n & m0.read;
    assign w_req1 = reset_n & (m1.read | m1.write);

    rr_arb2 #(
        .FIXED_PRI (FIXED_PRI)
    ) u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_req0   (w_req0),
        .i_req1   (w_req1),
        .o_grant0 (w_grant0),
        .o_grant1 (w_grant1)
    );

    assign m0.waitrequest = ~w_grant0;
    assign m1.waitrequest = ~w_grant1;

    assign mem_chipselect = w_grant0 | w_grant1;
    assign mem_clken      = reset_n;

    always_comb begin
        mem_address     = m0.address;
        mem_byteenable  = '1;
        mem_write       = 1'b0;
        mem_writedata   = '0;
        mem_debugaccess = 1'b0;
        if (w_grant1) begin
            mem_address     = m1.address;
            mem_byteenable  = m1.byteenable;
            mem_write       = m1.write;
            mem_writedata   = m1.writedata;
            mem_debugaccess = m1.debugaccess;
        end
    end

    // A simultaneous read+write from m1 is a write; its read half is dropped.
    assign w_rd_accept = w_grant0 | (w_grant1 & ~m1.write);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_pend  <= 1'b0;
            r_rd_owner <= PM_M_IFETCH;
        end else begin
            r_rd_pend  <= w_rd_accept;
            r_rd_owner <= w_grant1 ? PM_M_DATA : PM_M_IFETCH;
        end
    end

    assign m0.readdatavalid = r_rd_pend & (r_rd_owner == PM_M_IFETCH);
    assign m1.readdatavalid = r_rd_pend & (r_rd_owner == PM_M_DATA);
    assign m0.readdata      = mem_readdata;
    assign m1.readdata      = mem_readdata;

    assert property (@(posedge clk) disable iff (!reset_n) !(m1.read && m1.write));

endmodule

// File: tb/tb_program_mem_arbiter.sv
// Scoreboard bench for program_mem_arbiter: a behavioural memory sits behind the
// round-robin instance, and a second instance exercises fixed priority.
module tb_program_mem_arbiter;
    import program_mem_pkg::*;

    logic clk;
    logic reset_n;

    program_mem_arbiter_if m0If ();
    program_mem_arbiter_if m1If ();
    program_mem_arbiter_if fpM0If ();
    program_mem_arbiter_if fpM1If ();

    logic [9:0]  memAddress;
    logic [3:0]  memByteenable;
    logic        memChipselect;
    logic        memClken;
    logic        memWrite;
    logic [31:0] memWritedata;
    logic        memDebugaccess;
    logic [31:0] memReaddata;

    logic [9:0]  fpMemAddress;
    logic [3:0]  fpMemByteenable;
    logic        fpMemChipselect;
    logic        fpMemClken;
    logic        fpMemWrite;
    logic [31:0] fpMemWritedata;
    logic        fpMemDebugaccess;

    logic [31:0] memArray [0:1023];
    logic [31:0] shadowMem [0:1023];
    logic [31:0] exp0 [$];
    logic [31:0] exp1 [$];
    logic        expLast;
    int          errors;
    int          checks;

    program_mem_arbiter #(.FIXED_PRI(0)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .m0              (m0If),
        .m1              (m1If),
        .mem_address     (memAddress),
        .mem_byteenable  (memByteenable),
        .mem_chipselect  (memChipselect),
        .mem_clken       (memClken),
        .mem_write       (memWrite),
        .mem_writedata   (memWritedata),
        .mem_debugaccess (memDebugaccess),
        .mem_readdata    (memReaddata)
    );

    program_mem_arbiter #(.FIXED_PRI(1)) dutFp (
        .clk             (clk),
        .reset_n         (reset_n),
        .m0              (fpM0If),
        .m1              (fpM1If),
        .mem_address     (fpMemAddress),
        .mem_byteenable  (fpMemByteenable),
        .mem_chipselect  (fpMemChipselect),
        .mem_clken       (fpMemClken),
        .mem_write       (fpMemWrite),
        .mem_writedata   (fpMemWritedata),
        .mem_debugaccess (fpMemDebugaccess),
        .mem_readdata    (32'h0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory: writes need debugaccess, reads return data one cycle later.
    always @(posedge clk) begin
        if (memClken && memChipselect) begin
            if (memWrite) begin
                if (memDebugaccess) begin
                    for (int b = 0; b < 4; b++) begin
                        if (memByteenable[b]) memArray[memAddress][8*b +: 8] = memWritedata[8*b +: 8];
                    end
                end
            end else begin
                memReaddata <= memArray[memAddress];
            end
        end
    end

    always @(negedge clk) begin
        if (m0If.readdatavalid) begin
            checks++;
            if (exp0.size() == 0) begin
                errors++;
                $display("[TB] FAIL m0_rdv_unexpected: got valid with data %h, required no response", m0If.readdata);
            end else begin
                logic [31:0] e;
                e = exp0.pop_front();
                if (m0If.readdata !== e) begin
                    errors++;
                    $display("[TB] FAIL m0_readdata: got %h required %h", m0If.readdata, e);
                end
            end
        end
        if (m1If.readdatavalid) begin
            checks++;
            if (exp1.size() == 0) begin
                errors++;
                $display("[TB] FAIL m1_rdv_unexpected: got valid with data %h, required no response", m1If.readdata);
            end else begin
                logic [31:0] e;
                e = exp1.pop_front();
                if (m1If.readdata !== e) begin
                    errors++;
                    $display("[TB] FAIL m1_readdata: got %h required %h", m1If.readdata, e);
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic m1Write(input logic [9:0] addr, input logic [3:0] be, input logic [31:0] data, input logic dbg);
        bit accepted = 0;
        m1If.address = addr; m1If.byteenable = be; m1If.writedata = data;
        m1If.debugaccess = dbg; m1If.write = 1'b1;
        for (int c = 0; c < 20 && !accepted; c++) begin
            #1;
            accepted = !m1If.waitrequest;
            cycle();
        end
        m1If.write = 1'b0;
        if (!accepted) begin
            errors++;
            $display("[TB] FAIL m1_write_timeout: got no acceptance, required acceptance at %h", addr);
        end else begin
            expLast = 1'b1;
            if (dbg) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) shadowMem[addr][8*b +: 8] = data[8*b +: 8];
                end
            end
        end
    endtask

    task automatic m1Read(input logic [9:0] addr, input logic [31:0] expected);
        bit accepted = 0;
        m1If.address = addr; m1If.read = 1'b1;
        for (int c = 0; c < 20 && !accepted; c++) begin
            #1;
            accepted = !m1If.waitrequest;
            if (accepted) exp1.push_back(expected);
            cycle();
        end
        m1If.read = 1'b0;
        if (!accepted) begin
            errors++;
            $display("[TB] FAIL m1_read_timeout: got no acceptance, required acceptance at %h", addr);
        end else begin
            expLast = 1'b1;
        end
        cycle();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        m0If.address = 10'h010;
        m0If.read = 1'b1;
        #1;
        checks++;
        if (m0If.waitrequest !== 1'b1 || memChipselect !== 1'b0 || memClken !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got wait=%b cs=%b clken=%b, required 1 0 0",
                     m0If.waitrequest, memChipselect, memClken);
        end
        cycle();
        checks++;
        if (m0If.readdatavalid !== 1'b0 || m1If.readdatavalid !== 1'b0 || m1If.waitrequest !== 1'b1 || memWrite !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_rdv: got rdv0=%b rdv1=%b wait1=%b wr=%b, required 0 0 1 0",
                     m0If.readdatavalid, m1If.readdatavalid, m1If.waitrequest, memWrite);
        end
        reset_n = 1'b1;
        expLast = 1'b1;
        #1;
        checks++;
        if (m0If.waitrequest !== 1'b0 || memChipselect !== 1'b1 || memAddress !== 10'h010 || memClken !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_grant: got wait=%b cs=%b addr=%h clken=%b, required 0 1 010 1",
                     m0If.waitrequest, memChipselect, memAddress, memClken);
        end
        exp0.push_back(32'hDEADBEEF);
        expLast = 1'b0;
        cycle();
        m0If.read = 1'b0;
        cycle();
    endtask

    task automatic test_single_read();
        m0If.address = 10'h010;
        m0If.read = 1'b1;
        #1;
        checks++;
        if (m0If.waitrequest !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_wait: got %b required 0", m0If.waitrequest);
        end
        exp0.push_back(32'hDEADBEEF);
        expLast = 1'b0;
        cycle();
        m0If.read = 1'b0;
        checks++;
        if (m0If.readdatavalid !== 1'b1 || m1If.readdatavalid !== 1'b0 || m0If.readdata !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL single_response: got rdv0=%b rdv1=%b data=%h, required 1 0 deadbeef",
                     m0If.readdatavalid, m1If.readdatavalid, m0If.readdata);
        end
        cycle();
        checks++;
        if (m0If.readdatavalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_one_shot: got rdv0=%b required 0", m0If.readdatavalid);
        end
    endtask

    task automatic test_byte_write();
        m1If.address = 10'h005; m1If.byteenable = 4'b0010;
        m1If.writedata = 32'h0000AB00; m1If.debugaccess = 1'b1; m1If.write = 1'b1;
        #1;
        checks++;
        if (m1If.waitrequest !== 1'b0 || memWrite !== 1'b1 || memByteenable !== 4'b0010 ||
            memWritedata !== 32'h0000AB00 || memDebugaccess !== 1'b1 || memAddress !== 10'h005) begin
            errors++;
            $display("[TB] FAIL byte_write_cmd: got wait=%b wr=%b be=%b wd=%h dbg=%b addr=%h, required 0 1 0010 0000ab00 1 005",
                     m1If.waitrequest, memWrite, memByteenable, memWritedata, memDebugaccess, memAddress);
        end
        cycle();
        m1If.write = 1'b0;
        expLast = 1'b1;
        checks++;
        if (m1If.readdatavalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_no_response: got rdv1=%b required 0", m1If.readdatavalid);
        end
        m1Read(10'h005, 32'h1122AB44);
        m1Write(10'h005, 4'b0010, 32'h0000CD00, 1'b0);
        m1Read(10'h005, 32'h1122AB44);
    endtask

    task automatic test_contention();
        logic expG1;
        m0If.address = 10'h000;
        m1If.address = 10'h3FF;
        m0If.read = 1'b1;
        m1If.read = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            expG1 = (expLast == 1'b0);
            checks++;
            if (m0If.waitrequest !== expG1 || m1If.waitrequest !== !expG1) begin
                errors++;
                $display("[TB] FAIL contention_grant[%0d]: got wait0=%b wait1=%b, required %b %b",
                         i, m0If.waitrequest, m1If.waitrequest, expG1, !expG1);
            end
            if (expG1) exp1.push_back(shadowMem[10'h3FF]);
            else       exp0.push_back(shadowMem[10'h000]);
            expLast = expG1;
            cycle();
            checks++;
            if ((m0If.readdatavalid ^ m1If.readdatavalid) !== 1'b1) begin
                errors++;
                $display("[TB] FAIL contention_rdv[%0d]: got rdv0=%b rdv1=%b, required exactly one",
                         i, m0If.readdatavalid, m1If.readdatavalid);
            end
        end
        m0If.read = 1'b0;
        m1If.read = 1'b0;
        cycle();
    endtask

    task automatic test_fixed_pri();
        fpM0If.address = 10'h001;
        fpM1If.address = 10'h002;
        fpM0If.read = 1'b1;
        fpM1If.read = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (fpM1If.waitrequest !== 1'b0 || fpM0If.waitrequest !== 1'b1) begin
                errors++;
                $display("[TB] FAIL fixed_pri_grant[%0d]: got wait0=%b wait1=%b, required 1 0",
                         i, fpM0If.waitrequest, fpM1If.waitrequest);
            end
            cycle();
        end
        fpM1If.read = 1'b0;
        #1;
        checks++;
        if (fpM0If.waitrequest !== 1'b0 || fpMemAddress !== 10'h001) begin
            errors++;
            $display("[TB] FAIL fixed_pri_release: got wait0=%b addr=%h, required 0 001",
                     fpM0If.waitrequest, fpMemAddress);
        end
        cycle();
        fpM0If.read = 1'b0;
        checks++;
        if (fpM0If.readdatavalid !== 1'b1 || fpM1If.readdatavalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fixed_pri_owner: got rdv0=%b rdv1=%b, required 1 0",
                     fpM0If.readdatavalid, fpM1If.readdatavalid);
        end
        cycle();
    endtask

    task automatic test_reset_outstanding();
        m1If.address = 10'h3FF;
        m1If.read = 1'b1;
        #1;
        checks++;
        if (m1If.waitrequest !== 1'b0) begin
            errors++;
            $display("[TB] FAIL outstanding_accept: got wait1=%b required 0", m1If.waitrequest);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        m1If.read = 1'b0;
        #1;
        checks++;
        if (m1If.readdatavalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL outstanding_dropped: got rdv1=%b required 0", m1If.readdatavalid);
        end
        cycle();
        reset_n = 1'b1;
        expLast = 1'b1;
        cycle();
        checks++;
        if (m1If.readdatavalid !== 1'b0 || m0If.readdatavalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL outstanding_after_release: got rdv0=%b rdv1=%b, required 0 0",
                     m0If.readdatavalid, m1If.readdatavalid);
        end
        m1Read(10'h3FF, 32'h0BADF00D);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        expLast = 1'b1;
        reset_n = 1'b0;
        m0If.address = '0; m0If.read = 1'b0; m0If.write = 1'b0;
        m0If.byteenable = '0; m0If.writedata = '0; m0If.debugaccess = 1'b0;
        m1If.address = '0; m1If.read = 1'b0; m1If.write = 1'b0;
        m1If.byteenable = '0; m1If.writedata = '0; m1If.debugaccess = 1'b0;
        fpM0If.address = '0; fpM0If.read = 1'b0; fpM0If.write = 1'b0;
        fpM0If.byteenable = '0; fpM0If.writedata = '0; fpM0If.debugaccess = 1'b0;
        fpM1If.address = '0; fpM1If.read = 1'b0; fpM1If.write = 1'b0;
        fpM1If.byteenable = '0; fpM1If.writedata = '0; fpM1If.debugaccess = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        expLast = 1'b1;
        cycle();

        m1Write(10'h010, 4'hF, 32'hDEADBEEF, 1'b1);
        m1Write(10'h005, 4'hF, 32'h11223344, 1'b1);
        m1Write(10'h000, 4'hF, 32'hCAFE0000, 1'b1);
        m1Write(10'h3FF, 4'hF, 32'h0BADF00D, 1'b1);

        test_reset();
        test_single_read();
        test_byte_write();
        test_contention();
        test_fixed_pri();
        test_reset_outstanding();

        repeat (3) cycle();
        checks++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d/%0d pending responses, required 0/0",
                     exp0.size(), exp1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/program_mem_arbiter.md
Name: program_mem_arbiter

Overview:
- Two-master arbiter in front of the 1024x32 single-port on-chip program memory.
- Master 0 is the CPU instruction fetch port, which is read-only. Master 1 is the CPU data/debug port, which can read and write.
- Round-robin arbitration grants one Avalon-MM transfer per cycle.
- The memory has 1-cycle read latency, so the arbiter tags each read and steers `readdatavalid` back to the originating master.

Parameters:
- `ADDR_W`, 10, word address width (1024 words).
- `DATA_W`, 32, data width.
- `BE_W`, 4, byteenable width (`DATA_W`/8).
- `FIXED_PRI`, 0: 0 = round-robin; 1 = master 1 always wins contention.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `m0_address`  in  `ADDR_W`  instruction word address.
- `m0_read`  in  1  instruction read request.
- `m0_waitrequest`  out  1  high = request not accepted this cycle.
- `m0_readdata`  out  `DATA_W`  read data, valid only with `m0_readdatavalid`.
- `m0_readdatavalid`  out  1  read data valid for master 0.
- `m1_address`  in  `ADDR_W`  data word address.
- `m1_byteenable`  in  `BE_W`  byte lanes for the write.
- `m1_read`  in  1  data read request.
- `m1_write`  in  1  data write request.
- `m1_writedata`  in  `DATA_W`  write data.
- `m1_debugaccess`  in  1  write-enable qualifier, passed through to the memory.
- `m1_waitrequest`  out  1  high = request not accepted this cycle.
- `m1_readdata`  out  `DATA_W`  read data, valid only with `m1_readdatavalid`.
- `m1_readdatavalid`  out  1  read data valid for master 1.
- `mem_address`  out  `ADDR_W`  to memory.
- `mem_byteenable`  out  `BE_W`  to memory.
- `mem_chipselect`  out  1  to memory.
- `mem_clken`  out  1  to memory.
- `mem_write`  out  1  to memory.
- `mem_writedata`  out  `DATA_W`  to memory.
- `mem_debugaccess`  out  1  to memory.
- `mem_readdata`  in  `DATA_W`  from memory, valid 1 cycle after a read is accepted.

Behaviour:
- **Requests:** `req0 = m0_read`; `req1 = m1_read | m1_write`. If `m1_read` and `m1_write` are asserted together, the transfer is treated as a write and the read is ignored; a simulation assertion flags it.
- **Grant (combinational each cycle):**
  - Only one master requesting: that master is granted.
  - Both requesting: the master not recorded in `last_grant` wins; with `FIXED_PRI`=1, master 1 wins.
  - `last_grant` is a register, updated on every cycle in which a grant occurs.
- **Waitrequest:** `mX_waitrequest = ~grantX`. An idle master sees `waitrequest` high. Masters hold their command stable until `waitrequest` is low (standard Avalon).
- **Memory command:**
  - `mem_chipselect` = `grant0 | grant1`.
  - `mem_address` comes from the granted master.
  - `mem_write` = `grant1 & m1_write`.
  - `mem_byteenable` = `m1_byteenable` on a master-1 grant, otherwise all ones.
  - `mem_writedata` and `mem_debugaccess` come from master 1 on a master-1 grant, otherwise zero.
  - A master-1 write with `m1_debugaccess`=0 is still accepted (`waitrequest` low), but the memory ignores it.
- **Memory clock enable:** `mem_clken` = 1 whenever `reset_n` is high.
- **Read response pipeline:**
  - Registers `rd_pend` (1 bit) and `rd_owner` (1 bit), loaded every cycle: `rd_pend` = a read was granted this cycle; `rd_owner` = the granted master.
  - `mX_readdatavalid = rd_pend & (rd_owner == X)`.
  - `m0_readdata` and `m1_readdata` both equal `mem_readdata`.
  - Read latency is exactly 1 cycle after acceptance.
- **Throughput:** back-to-back accepted reads from alternating masters give one `readdatavalid` per cycle. A write occupies one cycle and produces no response.
- **Reset values:**
  - `last_grant` = 1 (master 0 wins the first tie).
  - `rd_pend` = 0, `rd_owner` = 0.
  - `m0_waitrequest` and `m1_waitrequest` = 1.
  - `readdatavalid` outputs = 0, `mem_chipselect` = 0, `mem_write` = 0, `mem_clken` = 0.
- **Reset mid-operation:** an outstanding read is dropped and no `readdatavalid` is issued after reset release. Arbitration resumes on the first cycle with `reset_n` high.
- **No request:** `mem_chipselect` = 0, `last_grant` is held, `rd_pend` → 0 next cycle.
- **Address wrap:** none. The address is passed unmodified within `ADDR_W`; the arbiter does no range check.

Decomposition:
- Shared package `program_mem_pkg`:
  - constants `PM_ADDR_W`=10, `PM_DATA_W`=32, `PM_BE_W`=4;
  - master index constants `PM_M_IFETCH`=0, `PM_M_DATA`=1.
- One natural sub-module, `rr_arb2`: two-requester round-robin grant logic holding the `last_grant` register, with the `FIXED_PRI` override.
- The top level holds command muxing and the read-tag pipeline.

Test Plan:
- **Reset:** assert `reset_n`=0 with `m0_read`=1 → `m0_waitrequest`=1, `mem_chipselect`=0, no `readdatavalid`. Release reset → `m0` granted on the first cycle.
- **Single master-0 read:** preload word 0x010 = 0xDEADBEEF; `m0_read` at address 0x010 → `waitrequest` low in cycle N; `m0_readdatavalid`=1 with 0xDEADBEEF in cycle N+1; `m1_readdatavalid` stays 0.
- **Contention, round-robin:** both masters read continuously (`m0` at 0x000, `m1` at 0x3FF) → grants alternate 0,1,0,1; each master receives one `readdatavalid` every 2 cycles with the correct data.
- **Byte write:** `m1_write` with byteenable=0b0010, writedata=0x0000AB00, debugaccess=1, at address 0x005 (old value 0x11223344) → a later read returns 0x1122AB44. Repeat with debugaccess=0 → the word is unchanged.
- **Fixed priority:** set `FIXED_PRI`=1 and drive both masters continuously for 8 cycles → `m1` granted all 8 cycles; `m0_waitrequest` stays 1. Drop `m1` → `m0` granted the next cycle.
- **Reset with read outstanding:** pulse `reset_n` low in the cycle after an accepted `m1` read → no `m1_readdatavalid` is asserted; the next `m1` read after release completes normally.
